// File: rtl/lfsr_pkg.sv
// Shared types, constants and the LFSR step function for the PRBS arbiter.
// The step is the x^32+x^22+x^2+x+1 polynomial in right-shift Galois form.
package lfsr_pkg;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 32'h00000001;

  typedef enum logic {
    S_SERVE = 1'b0,
    S_WARM  = 1'b1
  } arb_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    logic [LFSR_W-1:0] n;
    n = {q[0], q[31:23], q[22] ^ q[0], q[21:3], q[2] ^ q[0], q[1] ^ q[0]};
    return n;
  endfunction

endpackage

// File: rtl/lfsr_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping modulo NREQ.
module lfsr_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0]  rot;
  logic [PTR_W-1:0] off;
  logic [PTR_W:0]   sum;
  logic [PTR_W:0]   wrap;

  always_comb begin
    rot    = NREQ'({req, req} >> ptr);
    off    = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        off = PTR_W'(k);
      end
    end
    // rotated offset back to an absolute requester index
    sum    = {1'b0, ptr} + {1'b0, off};
    wrap   = (sum >= (PTR_W+1)'(NREQ)) ? sum - (PTR_W+1)'(NREQ) : sum;
    idx    = PTR_W'(wrap);
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/lfsr_prng_arbiter.sv
// Round-robin arbiter sharing one 32-bit PRBS generator among NREQ requesters.
// Optional grant counter output enabled by LFSR_ARB_STATS_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_SERVE | arbitrate req every edge, one word per grant, LFSR steps
// S_WARM  | post-seed warm-up: LFSR free-runs, req ignored, busy high
module lfsr_prng_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WARMUP = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rnd_data,
  output logic              rnd_valid,
  output logic              busy
`ifdef LFSR_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  arb_state_e        state, state_d;
  logic [LFSR_W-1:0] q, q_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic [7:0]        warm_cnt, warm_cnt_d;
  logic [NREQ-1:0]   gnt_d;
  logic [LFSR_W-1:0] data_d;
  logic              valid_d;

  logic [NREQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  lfsr_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d    = state;
    q_d        = q;
    ptr_d      = ptr;
    warm_cnt_d = warm_cnt;
    gnt_d      = '0;
    valid_d    = 1'b0;
    data_d     = rnd_data;
    // a seed strobe overrides both serving and warm-up
    if (seed_load) begin
      q_d        = (seed_val == '0) ? LFSR_RESET : seed_val;
      warm_cnt_d = WARM_INIT;
      state_d    = (WARMUP > 0) ? S_WARM : S_SERVE;
    end else begin
      case (state)
        S_SERVE: begin
          if (pick_any) begin
            gnt_d   = pick_onehot;
            valid_d = 1'b1;
            data_d  = q;
            q_d     = lfsr_next(q);
            ptr_d   = (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + PTR_W'(1);
          end
        end
        S_WARM: begin
          q_d        = lfsr_next(q);
          warm_cnt_d = warm_cnt - 8'd1;
          if (warm_cnt == 8'd1) state_d = S_SERVE;
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_SERVE;
      q         <= LFSR_RESET;
      ptr       <= '0;
      warm_cnt  <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      state     <= state_d;
      q         <= q_d;
      ptr       <= ptr_d;
      warm_cnt  <= warm_cnt_d;
      gnt       <= gnt_d;
      rnd_valid <= valid_d;
      rnd_data  <= data_d;
    end
  end

  assign busy = (state == S_WARM);

`ifdef LFSR_ARB_STATS_EN
  // saturating; seed loads deliberately leave it alone
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      grant_cnt <= '0;
    else if (valid_d && grant_cnt != 16'hFFFF)
      grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/lfsr_prng_arbiter.md
Name: lfsr_prng_arbiter

Overview:
- Shares one 32-bit PRBS generator between NREQ requesters, using round-robin arbitration.
- Each grant delivers one 32-bit pseudo-random word and advances the generator one step.
- Supports a runtime seed load, followed by a configurable warm-up period.
- Sits between the block-level random consumers (scramblers, test-pattern sources) and the shared LFSR datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WARMUP, 4, free-running LFSR steps after a seed load before grants resume (0..255).

Ports:
- sys_clk  input  1  system clock, rising edge
- sys_rst  input  1  asynchronous reset, active-high
- seed_load  input  1  single-cycle strobe: load seed_val into the LFSR
- seed_val  input  32  seed value
- req  input  NREQ  level request, one bit per requester
- gnt  output  NREQ  registered one-hot grant, high for one cycle
- rnd_data  output  32  word delivered to the granted requester, valid with rnd_valid
- rnd_valid  output  1  high in the same cycle as any gnt bit
- busy  output  1  high during warm-up; no grants are issued while high

Behaviour:
- Reset (asynchronous, active-high):
  - LFSR state q = 32'h00000001
  - state = S_SERVE, rr pointer = 0
  - gnt = 0, rnd_valid = 0, rnd_data = 0, busy = 0
- LFSR step (polynomial x^32+x^22+x^2+x+1, right-shift Galois form):
  - next[31] = q[0]
  - next[30:22] = q[31:23]
  - next[21] = q[22]^q[0]
  - next[20:2] = q[21:3]
  - next[1] = q[2]^q[0]
  - next[0] = q[1]^q[0]
- FSM states: S_SERVE, S_WARM.
- S_SERVE:
  - At each edge with req != 0, select the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - Register gnt = onehot(i), rnd_valid = 1, rnd_data = current q.
  - Advance q one step.
  - Set rr pointer = (i+1) mod NREQ.
  - Latency: req sampled at edge k; gnt, rnd_valid and rnd_data are valid in the cycle after edge k.
  - When req == 0: gnt = 0, rnd_valid = 0, q and pointer hold, rnd_data holds its last value.
- Held req: a requester that keeps req high is re-arbitrated every edge. A sole requester therefore receives back-to-back words, one per cycle.
- seed_load (from any state):
  - q = seed_val; if seed_val == 0, q = 32'h00000001 (lock-up guard).
  - Warm-up counter = WARMUP.
  - If WARMUP > 0: go to S_WARM, busy = 1. If WARMUP == 0: stay in S_SERVE.
  - gnt = 0 and rnd_valid = 0 on that edge.
  - The rr pointer is not changed.
- S_WARM:
  - q advances every cycle and the counter decrements.
  - req is ignored; it is not queued.
  - When the counter reaches 1, go to S_SERVE and clear busy on the same edge.
  - busy is high for exactly WARMUP cycles.
- Simultaneous events:
  - seed_load in the same cycle as req: the seed wins and no grant is issued.
  - seed_load during S_WARM: restarts the load and warm-up with the new seed.
- Reset mid-operation: immediately returns all outputs and state to their reset values.

Optional Feature:
- Macro: LFSR_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt [15:0]: total grants since reset, saturating at 16'hFFFF.
  - Cleared by sys_rst only; not cleared by seed_load.
- Undefined: the port, the counter and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W = 32
  - LFSR_RESET = 32'h00000001
  - FSM state enum {S_SERVE, S_WARM}
  - function lfsr_next(q) implementing the step above
- Sub-module: lfsr_rr_pick, combinational round-robin selector.
  - Inputs: req, ptr. Outputs: onehot grant, index, any.
  - Instantiated once.

Test Plan:
- Reset, then req=4'b0001 held for 3 edges -> rnd_data sequence 32'h00000001, 32'h80200003, 32'hC0300002; gnt=0001 each cycle.
- req=4'b1111 held for 5 edges after reset -> gnt 0001, 0010, 0100, 1000, 0001; rnd_data follows the LFSR sequence in order.
- seed_load with seed_val=0 and WARMUP=4, req=1111 held:
  - busy high for exactly 4 cycles, no gnt during busy.
  - First grant after busy carries q = lfsr_next^4(32'h1).
- seed_load and req=0100 in the same cycle -> no gnt that cycle; q = seed; rr pointer unchanged.
- Assert sys_rst for a partial cycle mid-warm-up:
  - busy = 0 and gnt = 0 immediately.
  - After release, req=0010 -> gnt=0010 and rnd_data = 32'h00000001.
- With LFSR_ARB_STATS_EN defined: 70000 continuous grants -> grant_cnt saturates at 16'hFFFF and does not wrap.
